// File: rtl/ram_window_scheduler.sv
// Shares a single-port feature RAM between a word-write loader and a KxK window reader,
// scanning every window of the configured image in raster order and presenting each one.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | RAM idle; round-robin grant between loader write and scan read
// WR      | loader word write in flight, waiting for ram_finish
// RD      | window read in flight at (row, col), waiting for ram_finish
// PRESENT | window held on RAM output; waits for win_ready, advances scan
// GAP     | one idle cycle so the RAM sees a fresh enable rise
module ram_window_scheduler #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int K       = 5,
    parameter int STRIDE  = 1,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] img_base,
    input  logic [ADDR_W-1:0] img_w,
    input  logic [ADDR_W-1:0] img_h,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [ADDR_W-1:0] win_row,
    output logic [ADDR_W-1:0] win_col,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              ram_enable,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_address,
    output logic [ADDR_W-1:0] ram_offset,
    output logic [DATA_W-1:0] ram_input_data,
    input  logic              ram_finish
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int XW = ADDR_W + 2;
    localparam logic [TW-1:0]     TO_LOAD = TW'(TIMEOUT);
    localparam logic [XW-1:0]     STEP_X  = XW'(STRIDE);
    localparam logic [XW-1:0]     K_X     = XW'(K);
    localparam logic [ADDR_W-1:0] STEP_A  = ADDR_W'(STRIDE);

    typedef enum logic [2:0] {IDLE, WR, RD, PRESENT, GAP} state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] w_q;
    logic [ADDR_W-1:0] h_q;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    logic              busy_q;
    logic              done_q;
    logic              error_q;
    logic              prio_wr;
    logic [TW-1:0]     tcnt;

    logic grant_wr;
    logic grant_rd;
    logic timeout;
    logic win_adv;
    logic col_wrap;
    logic scan_last;
    logic degenerate;
    logic tcnt_last;

    // Extended-width compares so col+STRIDE+K cannot wrap around ADDR_W.
    always_comb begin
        col_wrap   = ({2'b00, col} + STEP_X + K_X) > {2'b00, w_q};
        scan_last  = ({2'b00, row} + STEP_X + K_X) > {2'b00, h_q};
        degenerate = ({2'b00, img_w} < K_X) || ({2'b00, img_h} < K_X);
        tcnt_last  = (tcnt == TW'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_wr       = 1'b0;
        grant_rd       = 1'b0;
        timeout        = 1'b0;
        win_adv        = 1'b0;
        ram_enable     = 1'b0;
        ram_write      = 1'b0;
        ram_address    = '0;
        ram_input_data = '0;
        wr_ack         = 1'b0;
        win_valid      = 1'b0;
        case (state)
            IDLE: begin
                if (wr_req && (!busy_q || prio_wr)) begin
                    grant_wr  = 1'b1;
                    state_nxt = WR;
                end else if (busy_q) begin
                    grant_rd  = 1'b1;
                    state_nxt = RD;
                end
            end
            WR: begin
                ram_enable     = 1'b1;
                ram_write      = 1'b1;
                ram_address    = wr_addr;
                ram_input_data = wr_data;
                if (ram_finish) begin
                    wr_ack    = 1'b1;
                    state_nxt = GAP;
                end else if (tcnt_last) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            RD: begin
                ram_enable  = 1'b1;
                ram_address = row_base + col;
                if (ram_finish) begin
                    state_nxt = PRESENT;
                end else if (tcnt_last) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            PRESENT: begin
                win_valid = 1'b1;
                if (win_ready) begin
                    win_adv   = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_base <= '0;
            w_q      <= '0;
            h_q      <= '0;
            row      <= '0;
            col      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            prio_wr  <= 1'b1;
            tcnt     <= '0;
        end else begin
            done_q <= 1'b0;
            // Down-counter reloads on every grant; the grant also hands priority to the other side.
            if (grant_wr) begin
                tcnt    <= TO_LOAD;
                prio_wr <= 1'b0;
            end else if (grant_rd) begin
                tcnt    <= TO_LOAD;
                prio_wr <= 1'b1;
            end else if ((state == WR || state == RD) && !ram_finish) begin
                tcnt <= tcnt - 1'b1;
            end
            if (win_adv) begin
                if (col_wrap) begin
                    col      <= '0;
                    row      <= row + STEP_A;
                    row_base <= row_base + STEP_A * w_q;
                    if (scan_last) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end else begin
                    col <= col + STEP_A;
                end
            end
            if (timeout) begin
                error_q <= 1'b1;
                busy_q  <= 1'b0;
            end
            if (start && !busy_q) begin
                row_base <= img_base;
                w_q      <= img_w;
                h_q      <= img_h;
                row      <= '0;
                col      <= '0;
                error_q  <= 1'b0;
                if (degenerate) begin
                    done_q <= 1'b1;
                end else begin
                    busy_q <= 1'b1;
                end
            end
        end
    end

    assign win_row    = row;
    assign win_col    = col;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign ram_offset = w_q;

endmodule
